// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, defaults and helpers for the sequential binary-to-BCD converter
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BIN_W_DEF = 14;
    localparam int NDIG_DEF  = 4;
    localparam int CNT_W_DEF = $clog2(BIN_W_DEF + 1);

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble correction: add 3 to a BCD digit that is 5 or more
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj
);

    // Wraps inside 4 bits; a valid digit 5..9 maps to 8..12, so no carry is ever lost.
    assign adj = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-clock binary-to-BCD converter with start/busy/done handshake
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic                overflow
);

    localparam int                CW     = $clog2(BIN_W + 1);
    localparam int unsigned       MAXVAL = pow10(NDIG) - 1;
    localparam logic [CW-1:0]     LAST   = CW'(BIN_W - 1);
    localparam logic [4*NDIG-1:0] ALL9   = {NDIG{4'h9}};

    state_t              state;
    logic [BIN_W-1:0]    bin_sr;
    logic [BIN_W-1:0]    bin_next;
    logic [4*NDIG-1:0]   acc;
    logic [4*NDIG-1:0]   acc_adj;
    logic [4*NDIG-1:0]   acc_next;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;

    for (genvar g = 0; g < NDIG; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (acc[4*g +: 4]),
            .adj   (acc_adj[4*g +: 4])
        );
    end

    // Bits shifted out of the top digit fall off; only matters when ovf_pend masks the result.
    assign {acc_next, bin_next} = {acc_adj, bin_sr} << 1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
            bin_sr   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= bin_in;
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_pend <= 64'(bin_in) > 64'(MAXVAL);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc    <= acc_next;
                    bin_sr <= bin_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd_out  <= ovf_pend ? ALL9 : acc_next;
                        overflow <= ovf_pend;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq against a decimal reference model
module tb_bin_to_bcd_seq;

    localparam int BIN_W = 14;
    localparam int NDIG  = 4;
    localparam int LAT   = BIN_W + 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [BIN_W-1:0] bin_in = '0;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic [15:0]      bcd_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
        .clock    (clock),
        .reset    (reset),
        .bin_in   (bin_in),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: clamp to 9999, split into digits by division.
    function automatic logic [16:0] ref_conv(input int v);
        int          c;
        logic [15:0] r;
        c = (v > 9999) ? 9999 : v;
        for (int d = 0; d < NDIG; d++) begin
            r[4*d +: 4] = 4'(c % 10);
            c = c / 10;
        end
        return {(v > 9999), r};
    endfunction

    // Transaction-level model: a conversion takes BIN_W cycles of busy, then one done cycle.
    int          m_rem;
    int          m_val;
    logic        m_done;
    logic        m_ovf;
    logic [15:0] m_bcd;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rem  <= 0;
            m_val  <= 0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_bcd  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem <= BIN_W;
                    m_val <= int'(bin_in);
                end
            end else begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_done <= 1'b1;
                    {m_ovf, m_bcd} <= ref_conv(m_val);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("cyc_busy", 32'(busy), 32'(m_rem != 0));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_bcd", 32'(bcd_out), 32'(m_bcd));
            check("cyc_ovf", 32'(overflow), 32'(m_ovf));
            check("cyc_done_busy_overlap", 32'(done & busy), 32'd0);
            for (int d = 0; d < NDIG; d++) begin
                if (bcd_out[4*d +: 4] > 4'd9) begin
                    check("cyc_digit_range", 32'(bcd_out[4*d +: 4]), 32'd9);
                end
            end
        end
    end

    // Pulse start for one cycle and wait for done; returns latency and busy-cycle count.
    task automatic convert(input int v, output int lat, output int nbusy);
        bin_in = BIN_W'(v);
        start  = 1'b1;
        lat    = 0;
        nbusy  = 0;
        forever begin
            @(negedge clock);
            lat++;
            if (lat == 1) start = 1'b0;
            if (busy) nbusy++;
            if (done) break;
            if (lat > 3 * LAT) begin
                check("convert_timeout", 32'(lat), 32'(LAT));
                break;
            end
        end
    endtask

    task automatic convert_expect(input string name, input int v,
                                  input logic [15:0] exp_bcd, input logic exp_ovf);
        int lat, nbusy;
        convert(v, lat, nbusy);
        check({name, "_lat"}, 32'(lat), 32'(LAT));
        check({name, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        int lat, nbusy, last_done, ndone;

        check("model_1234", 32'(ref_conv(1234)), {15'd0, 1'b0, 16'h1234});
        check("model_16383", 32'(ref_conv(16383)), {15'd0, 1'b1, 16'h9999});
        check("model_42", 32'(ref_conv(42)), {15'd0, 1'b0, 16'h0042});

        @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        convert(1234, lat, nbusy);
        check("c1234_lat", 32'(lat), 32'd15);
        check("c1234_busy_cycles", 32'(nbusy), 32'd14);
        check("c1234_bcd", 32'(bcd_out), 32'h1234);
        check("c1234_ovf", 32'(overflow), 32'd0);

        convert_expect("c0", 0, 16'h0000, 1'b0);
        convert_expect("c9999", 9999, 16'h9999, 1'b0);
        convert_expect("c10000", 10000, 16'h9999, 1'b1);
        convert_expect("c16383", 16383, 16'h9999, 1'b1);
        convert_expect("c42", 42, 16'h0042, 1'b0);
        repeat (3) @(negedge clock);
        check("hold_bcd", 32'(bcd_out), 32'h0042);
        check("hold_done", 32'(done), 32'd0);

        // start held high: back-to-back conversions, one done every LAT cycles
        bin_in    = BIN_W'(7);
        start     = 1'b1;
        last_done = -1;
        ndone     = 0;
        for (int c = 1; c <= 3 * LAT + 2; c++) begin
            @(negedge clock);
            if (done) begin
                if (last_done >= 0) check("b2b_spacing", 32'(c - last_done), 32'(LAT));
                last_done = c;
                ndone++;
                check("b2b_bcd", 32'(bcd_out), 32'h0007);
            end
        end
        check("b2b_count", 32'(ndone), 32'd3);
        start = 1'b0;
        while (busy) @(negedge clock);
        @(negedge clock);

        // start pulses during busy carrying 555 must not disturb the 7 in flight
        bin_in = BIN_W'(7);
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        bin_in = BIN_W'(555);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            start = (c % 2 == 0);
        end
        start = 1'b0;
        for (int c = 0; c < 2 * LAT && !done; c++) @(negedge clock);
        check("ign_done", 32'(done), 32'd1);
        check("ign_bcd", 32'(bcd_out), 32'h0007);
        @(negedge clock);
        check("ign_no_requeue", 32'(busy), 32'd0);

        // async reset mid-conversion
        convert_expect("pre_rst", 1234, 16'h1234, 1'b0);
        bin_in = BIN_W'(8765);
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_bcd", 32'(bcd_out), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 2 * LAT; c++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("arst_no_done", 32'(ndone), 32'd0);
        convert_expect("c8765", 8765, 16'h8765, 1'b0);

        // sweep; the per-cycle compare process checks every result against the model
        for (int i = 0; i < 1000; i++) begin
            int v;
            v = (i < 4) ? 9998 + i : int'($urandom_range(0, 16383));
            convert(v, lat, nbusy);
            check("sweep_lat", 32'(lat), 32'(LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
